pipe_controller: RTL and testbench

Pipelined control and hazard unit for the 5-stage MIPS datapath. Decodes `op`/`funct` in Decode and carries the control word through E/M/W pipeline registers. Tracks the destination register in M and W. Generates every control and hazard input the datapath consumes: stall, flush, forwarding selects and branch redirect. It replaces the separate control-unit and hazard-unit glue at the datapath boundary.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/ctrl_decode.sv | 56 +++++
 rtl/pipe_controller.sv | 106 ++++++++++
 tb/tb_pipe_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : opcode/funct/ALU/forward-select encodings and the control word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Execute operand select; register $0 is never forwarded and M beats W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wreg_m,
                                         input logic       rw_m,
                                         input logic [4:0] wreg_w,
                                         input logic       rw_w);
    if (src != 5'd0 && src == wreg_m && rw_m)      return FWD_MEM;
    else if (src != 5'd0 && src == wreg_w && rw_w) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode : combinational main decoder plus ALU decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FUNCT_ADD: ctrl.alucontrol = ALU_ADD;
          FUNCT_SUB: ctrl.alucontrol = ALU_SUB;
          FUNCT_AND: ctrl.alucontrol = ALU_AND;
          FUNCT_OR:  ctrl.alucontrol = ALU_OR;
          FUNCT_SLT: ctrl.alucontrol = ALU_SLT;
          default:   ctrl = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipe_controller.sv
// ---------------------------------------------------------------------------
// pipe_controller : pipelined control word (E/M/W) plus hazard/forward unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       equalID,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  output logic       pcsrcD,
  output logic       regdstE,
  output logic       alusrcE,
  output logic [2:0] alucontrolE,
  output logic       memwriteM,
  output logic       memtoregW,
  output logic       regwriteW,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  ctrl_t      dec;
  logic       regwriteE, memtoregE, memwriteE;
  logic       regwriteM, memtoregM;
  logic [4:0] writeregM, writeregW;
  logic       lwstall, branchstall;

  ctrl_decode u_ctrl_decode (
    .op    (op),
    .funct (funct),
    .ctrl  (dec)
  );

  // A flush inserts a bubble into E while M and W keep advancing.
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      regwriteE   <= 1'b0;
      memtoregE   <= 1'b0;
      memwriteE   <= 1'b0;
      alucontrolE <= 3'b000;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
    end else begin
      regwriteE   <= dec.regwrite;
      memtoregE   <= dec.memtoreg;
      memwriteE   <= dec.memwrite;
      alucontrolE <= dec.alucontrol;
      alusrcE     <= dec.alusrc;
      regdstE     <= dec.regdst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwriteM <= 1'b0;
      memtoregM <= 1'b0;
      memwriteM <= 1'b0;
      writeregM <= 5'd0;
      regwriteW <= 1'b0;
      memtoregW <= 1'b0;
      writeregW <= 5'd0;
    end else begin
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      memwriteM <= memwriteE;
      writeregM <= writeregE;
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
      writeregW <= writeregM;
    end
  end

  assign pcsrcD = dec.branch & equalID & ~reset;

  assign forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
  assign forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);

  // Stall detection deliberately does not exempt $0.
  assign lwstall     = memtoregE && ((rsD == rtE) || (rtD == rtE));
  assign branchstall = dec.branch &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

  assign stallF = lwstall | branchstall;
  assign stallD = lwstall | branchstall;
  assign flushE = lwstall | branchstall;

endmodule

`default_nettype wire

// File: tb/tb_pipe_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_controller : directed bench for pipe_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       equalID;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE;
  logic       pcsrcD, regdstE, alusrcE, memwriteM, memtoregW, regwriteW;
  logic [2:0] alucontrolE;
  logic       stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;

  int checks = 0;
  int errors = 0;

  pipe_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .equalID     (equalID),
    .rsD         (rsD),
    .rtD         (rtD),
    .rsE         (rsE),
    .rtE         (rtE),
    .writeregE   (writeregE),
    .pcsrcD      (pcsrcD),
    .regdstE     (regdstE),
    .alusrcE     (alusrcE),
    .alucontrolE (alucontrolE),
    .memwriteM   (memwriteM),
    .memtoregW   (memtoregW),
    .regwriteW   (regwriteW),
    .stallF      (stallF),
    .stallD      (stallD),
    .flushE      (flushE),
    .forwardAD   (forwardAD),
    .forwardBD   (forwardBD),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] rs, input logic [4:0] rt);
    op = o; funct = f; rsD = rs; rtD = rt;
  endtask

  task automatic set_e(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr);
    rsE = rs; rtE = rt; writeregE = wr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(6'b111111, 6'd0, 5'd0, 5'd0);
    set_e(5'd0, 5'd0, 5'd0);
    equalID = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(6'b100011, 6'd0, 5'd0, 5'd0);
    set_e(5'd0, 5'd0, 5'd0);
    equalID = 1'b1;
    tick();
    tick();
    checks++; if ({regdstE, alusrcE, alucontrolE} !== 5'b0) begin errors++;
      $display("FAIL reset_E: got %b expected 00000", {regdstE, alusrcE, alucontrolE}); end
    checks++; if ({memwriteM, memtoregW, regwriteW} !== 3'b0) begin errors++;
      $display("FAIL reset_MW: got %b expected 000", {memwriteM, memtoregW, regwriteW}); end
    checks++; if ({stallF, stallD, flushE, forwardAD, forwardBD} !== 5'b0) begin errors++;
      $display("FAIL reset_hazard: got %b expected 00000", {stallF, stallD, flushE, forwardAD, forwardBD}); end
    checks++; if ({forwardAE, forwardBE} !== 4'b0) begin errors++;
      $display("FAIL reset_fwdE: got %b expected 0000", {forwardAE, forwardBE}); end
    op = 6'b000100;
    #1;
    checks++; if (pcsrcD !== 1'b0) begin errors++;
      $display("FAIL reset_pcsrc: got %b expected 0", pcsrcD); end
    reset = 1'b0;
    op = 6'b111111;
    #1;
  endtask

  task automatic test_rtype();
    do_reset();
    set_d(6'b000000, 6'b100010, 5'd0, 5'd0);
    set_e(5'd0, 5'd0, 5'd9);
    tick();
    checks++; if ({regdstE, alusrcE, alucontrolE} !== 5'b10110) begin errors++;
      $display("FAIL rtype_E: got %b expected 10110", {regdstE, alusrcE, alucontrolE}); end
    set_d(6'b111111, 6'd0, 5'd0, 5'd0);
    tick();
    rsE = 5'd9;
    #1;
    checks++; if (forwardAE !== 2'b10) begin errors++;
      $display("FAIL rtype_fwdM: got %b expected 10", forwardAE); end
    tick();
    checks++; if ({regwriteW, memtoregW} !== 2'b10) begin errors++;
      $display("FAIL rtype_W: got %b expected 10", {regwriteW, memtoregW}); end
    checks++; if (forwardAE !== 2'b01) begin errors++;
      $display("FAIL rtype_fwdW: got %b expected 01", forwardAE); end
  endtask

  task automatic test_decode_table();
    logic [5:0] t_op [10];
    logic [5:0] t_fn [10];
    logic [4:0] t_e  [10];
    logic       t_mw [10];
    logic       t_rw [10];
    logic       t_mr [10];
    t_op = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100011,
             6'b101011, 6'b000100, 6'b001000, 6'b000000, 6'b000010};
    t_fn = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
             6'b000000, 6'b000000, 6'b000000, 6'b111111, 6'b000000};
    // {regdst, alusrc, alucontrol}
    t_e  = '{5'b10010, 5'b10000, 5'b10001, 5'b10111, 5'b01010,
             5'b01010, 5'b00110, 5'b01010, 5'b00000, 5'b00000};
    t_mw = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    t_rw = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
    t_mr = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    do_reset();
    set_e(5'd30, 5'd30, 5'd31);
    for (int i = 0; i < 10; i++) begin
      set_d(t_op[i], t_fn[i], 5'd0, 5'd0);
      tick();
      checks++; if ({regdstE, alusrcE, alucontrolE} !== t_e[i]) begin errors++;
        $display("FAIL decode_E[%0d]: got %b expected %b", i, {regdstE, alusrcE, alucontrolE}, t_e[i]); end
      checks++; if (memwriteM !== ((i >= 1) ? t_mw[i-1] : 1'b0)) begin errors++;
        $display("FAIL decode_M[%0d]: got %b", i, memwriteM); end
      checks++; if ({regwriteW, memtoregW} !== ((i >= 2) ? {t_rw[i-2], t_mr[i-2]} : 2'b00)) begin errors++;
        $display("FAIL decode_W[%0d]: got %b", i, {regwriteW, memtoregW}); end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(6'b100011, 6'd0, 5'd1, 5'd5);
    tick();
    set_e(5'd1, 5'd5, 5'd5);
    set_d(6'b000000, 6'b100000, 5'd5, 5'd6);
    #1;
    checks++; if ({stallF, stallD, flushE} !== 3'b111) begin errors++;
      $display("FAIL lu_stall: got %b expected 111", {stallF, stallD, flushE}); end
    tick();
    checks++; if ({regdstE, alusrcE, alucontrolE} !== 5'b0) begin errors++;
      $display("FAIL lu_bubble: got %b expected 00000", {regdstE, alusrcE, alucontrolE}); end
    checks++; if ({stallF, stallD, flushE} !== 3'b000) begin errors++;
      $display("FAIL lu_release: got %b expected 000", {stallF, stallD, flushE}); end
    set_e(5'd5, 5'd6, 5'd8);
    tick();
    checks++; if ({forwardAE, forwardBE} !== 4'b0100) begin errors++;
      $display("FAIL lu_fwdW: got %b expected 0100", {forwardAE, forwardBE}); end
    checks++; if ({regwriteW, memtoregW, regdstE} !== 3'b111) begin errors++;
      $display("FAIL lu_pipe: got %b expected 111", {regwriteW, memtoregW, regdstE}); end
  endtask

  task automatic test_forward_priority();
    do_reset();
    set_d(6'b000000, 6'b100000, 5'd0, 5'd0);
    set_e(5'd0, 5'd0, 5'd3);
    tick();
    tick();
    tick();
    set_e(5'd3, 5'd3, 5'd0);
    #1;
    checks++; if ({forwardAE, forwardBE} !== 4'b1010) begin errors++;
      $display("FAIL fp_mem_wins: got %b expected 1010", {forwardAE, forwardBE}); end
    tick();
    set_e(5'd0, 5'd0, 5'd0);
    #1;
    checks++; if ({forwardAE, forwardBE} !== 4'b0000) begin errors++;
      $display("FAIL fp_zero: got %b expected 0000", {forwardAE, forwardBE}); end
    rsE = 5'd3;
    #1;
    checks++; if (forwardAE !== 2'b01) begin errors++;
      $display("FAIL fp_wb_only: got %b expected 01", forwardAE); end
  endtask

  task automatic test_branch();
    do_reset();
    set_d(6'b000100, 6'd0, 5'd1, 5'd2);
    equalID = 1'b1;
    #1;
    checks++; if ({pcsrcD, stallF} !== 2'b10) begin errors++;
      $display("FAIL br_taken: got %b expected 10", {pcsrcD, stallF}); end
    equalID = 1'b0;
    #1;
    checks++; if (pcsrcD !== 1'b0) begin errors++;
      $display("FAIL br_not_taken: got %b expected 0", pcsrcD); end
    set_d(6'b001000, 6'd0, 5'd0, 5'd4);
    tick();
    set_e(5'd0, 5'd4, 5'd4);
    set_d(6'b000100, 6'd0, 5'd4, 5'd2);
    equalID = 1'b1;
    #1;
    checks++; if ({stallF, stallD, flushE} !== 3'b111) begin errors++;
      $display("FAIL br_alu_stall: got %b expected 111", {stallF, stallD, flushE}); end
    tick();
    checks++; if ({stallF, forwardAD, forwardBD} !== 3'b010) begin errors++;
      $display("FAIL br_alu_fwd: got %b expected 010", {stallF, forwardAD, forwardBD}); end
  endtask

  task automatic test_branch_load();
    do_reset();
    set_d(6'b100011, 6'd0, 5'd0, 5'd7);
    tick();
    set_e(5'd0, 5'd7, 5'd7);
    set_d(6'b000100, 6'd0, 5'd1, 5'd7);
    equalID = 1'b1;
    #1;
    checks++; if (stallF !== 1'b1) begin errors++;
      $display("FAIL bl_stall1: got %b expected 1", stallF); end
    tick();
    set_e(5'd0, 5'd0, 5'd0);
    #1;
    checks++; if ({stallF, flushE} !== 2'b11) begin errors++;
      $display("FAIL bl_stall2: got %b expected 11", {stallF, flushE}); end
    tick();
    checks++; if ({stallF, forwardAD, forwardBD, pcsrcD} !== 4'b0001) begin errors++;
      $display("FAIL bl_release: got %b expected 0001", {stallF, forwardAD, forwardBD, pcsrcD}); end
    equalID = 1'b0;
    #1;
    checks++; if (pcsrcD !== 1'b0) begin errors++;
      $display("FAIL bl_not_taken: got %b expected 0", pcsrcD); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_d(6'b100011, 6'd0, 5'd0, 5'd2);
    tick();
    set_e(5'd0, 5'd2, 5'd2);
    set_d(6'b000000, 6'b100000, 5'd2, 5'd3);
    #1;
    checks++; if (stallF !== 1'b1) begin errors++;
      $display("FAIL rms_pre: got %b expected 1", stallF); end
    reset = 1'b1;
    tick();
    checks++; if ({stallF, stallD, flushE} !== 3'b000) begin errors++;
      $display("FAIL rms_cancel: got %b expected 000", {stallF, stallD, flushE}); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_decode_table();
    test_load_use();
    test_forward_priority();
    test_branch();
    test_branch_load();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
